// File: rtl/sha256_padder_if.sv
// sha256_padder_if: memory read port and padded-block stream of the SHA-256 padder.
interface sha256_padder_if;
    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_read_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    modport master (
        output mem_addr, mem_we, blk_valid, blk_data, blk_last,
        input  mem_read_data, blk_ready
    );
    modport slave (
        input  mem_addr, mem_we, blk_valid, blk_data, blk_last,
        output mem_read_data, blk_ready
    );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: fetches a big-endian message from word memory and emits padded 512-bit SHA-256 blocks.
module sha256_padder (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             message_addr,
    input  logic [31:0]             size,
    output logic                    busy,
    output logic                    done,
    sha256_padder_if.master         bus
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

    state_t            state_q;
    logic [31:0]       addr_q, size_q, nblk_q, blk_q;
    logic [4:0]        w_q;
    logic [0:15][31:0] data_q;
    logic [15:0]       mem_addr_q;
    logic              valid_q, last_q, busy_q, done_q;

    logic [3:0]  k;
    logic [31:0] g, rem, nf_g, nb_g, d, word_d;
    logic        is_last;

    // Word k is captured while the counter shows k+1, one cycle after its fetch.
    always_comb begin
        k       = 4'(w_q - 5'd1);
        g       = (blk_q << 6) + {26'd0, k, 2'd0};
        rem     = size_q - g;
        is_last = blk_q == nblk_q - 32'd1;
        nf_g    = (blk_q << 6) + (32'(w_q) << 2) + 32'd4;
        nb_g    = (blk_q + 32'd1) << 6;
        d       = bus.mem_read_data;
        word_d  = is_last && k == 4'd14 ? size_q >> 29
                : is_last && k == 4'd15 ? size_q << 3
                : g > size_q            ? 32'd0
                : g == size_q           ? 32'h8000_0000
                : rem >= 32'd4          ? d
                : rem == 32'd1          ? {d[31:24], 8'h80, 16'd0}
                : rem == 32'd2          ? {d[31:16], 8'h80, 8'd0}
                :                         {d[31:8], 8'h80};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            nblk_q     <= '0;
            blk_q      <= '0;
            w_q        <= '0;
            data_q     <= '0;
            mem_addr_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    addr_q  <= message_addr;
                    size_q  <= size;
                    nblk_q  <= ((size + 32'd8) >> 6) + 32'd1;
                    blk_q   <= '0;
                    w_q     <= '0;
                    busy_q  <= 1'b1;
                    state_q <= FILL;
                    if (size != 32'd0) mem_addr_q <= message_addr[15:0];
                end
                FILL: begin
                    if (w_q != 5'd0) data_q[k] <= word_d;
                    if (w_q < 5'd15 && nf_g < size_q)
                        mem_addr_q <= 16'(addr_q + (blk_q << 4) + 32'(w_q) + 32'd1);
                    if (w_q == 5'd16) begin
                        w_q     <= '0;
                        valid_q <= 1'b1;
                        last_q  <= is_last;
                        state_q <= HOLD;
                    end else begin
                        w_q <= w_q + 5'd1;
                    end
                end
                HOLD: if (bus.blk_ready) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        blk_q   <= blk_q + 32'd1;
                        state_q <= FILL;
                        if (nb_g < size_q) mem_addr_q <= 16'(addr_q + ((blk_q + 32'd1) << 4));
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = 1'b0;
    assign bus.blk_valid = valid_q;
    assign bus.blk_data  = data_q;
    assign bus.blk_last  = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: randomized and directed messages checked against a byte-level padding model.
module tb_sha256_padder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] message_addr = '0;
    logic [31:0] size = '0;
    logic        busy, done;
    logic [31:0] mem [0:65535];
    logic [31:0] rdata;
    logic [15:0] last_addr;
    logic [511:0] last_blk;
    int          n_chk = 0;
    int          n_fail = 0;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clk(clk), .reset(reset), .start(start), .message_addr(message_addr),
        .size(size), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rdata <= mem[bus.mem_addr];
    assign bus.mem_read_data = rdata;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Padded message as a byte stream: data, 0x80, zeros, 64-bit big-endian bit length.
    function automatic logic [511:0] exp_blk(input logic [31:0] a, input int sz, input int b, input int nb);
        logic [511:0] r = '0;
        logic [63:0]  len = 64'(sz) << 3;
        int           tot = nb * 64;
        int           idx;
        logic [31:0]  wd;
        logic [7:0]   by;
        for (int j = 0; j < 64; j++) begin
            idx = 64 * b + j;
            wd  = mem[16'(a + 32'(idx / 4))];
            by  = idx < sz ? wd[31 - 8 * (idx % 4) -: 8]
                : idx == sz ? 8'h80
                : idx >= tot - 8 ? len[63 - 8 * (idx - (tot - 8)) -: 8]
                : 8'h00;
            r[511 - 8 * j -: 8] = by;
        end
        return r;
    endfunction

    // Call at #1 after a posedge with the DUT idle; returns at #1 after the DONE->IDLE edge.
    task automatic run_msg(input logic [31:0] a, input int sz, input int stall, input int stop_at = -1);
        int nb = (sz + 72) / 64;
        int cnt;
        logic [511:0] eb;
        message_addr = a;
        size = 32'(sz);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < nb; b++) begin
            cnt = 0;
            while (!bus.blk_valid && cnt < 40) begin
                if (cnt == stop_at) return;
                if (cnt < 16) begin
                    if (64 * b + 4 * cnt < sz) last_addr = 16'(a + 32'(16 * b + cnt));
                    chk("mem_addr", 512'(bus.mem_addr), 512'(last_addr));
                end
                @(posedge clk); #1;
                cnt++;
            end
            chk("latency", 512'(cnt), 512'(17));
            if (!bus.blk_valid) return;
            eb = exp_blk(a, sz, b, nb);
            chk("blk_data", bus.blk_data, eb);
            chk("blk_last", 512'(bus.blk_last), 512'(b == nb - 1));
            chk("busy", 512'(busy), 512'(1));
            for (int s = 0; s < stall; s++) begin
                start = 1'b1;
                message_addr = $urandom;
                size = 32'($urandom_range(0, 200));
                @(posedge clk); #1;
                start = 1'b0;
                chk("hold_valid", 512'(bus.blk_valid), 512'(1));
                chk("hold_data", bus.blk_data, eb);
                chk("hold_last", 512'(bus.blk_last), 512'(b == nb - 1));
                chk("hold_addr", 512'(bus.mem_addr), 512'(last_addr));
            end
            last_blk = bus.blk_data;
            bus.blk_ready = 1'b1;
            @(posedge clk); #1;
            bus.blk_ready = 1'b0;
            chk("valid_drop", 512'(bus.blk_valid), 512'(0));
            chk("done", 512'(done), 512'(b == nb - 1));
            chk("busy_xfer", 512'(busy), 512'(1));
        end
        @(posedge clk); #1;
        chk("done_end", 512'(done), 512'(0));
        chk("busy_end", 512'(busy), 512'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_done"}, 512'(done), 512'(0));
        chk({tag, "_valid"}, 512'(bus.blk_valid), 512'(0));
        chk({tag, "_last"}, 512'(bus.blk_last), 512'(0));
        chk({tag, "_we"}, 512'(bus.mem_we), 512'(0));
        chk({tag, "_addr"}, 512'(bus.mem_addr), 512'(0));
        chk({tag, "_data"}, bus.blk_data, 512'(0));
    endtask

    initial begin
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h0040] = 32'h6162_6300;
        last_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        run_msg(32'h0040, 3, 0);
        chk("abc_w0", 512'(last_blk[511:480]), 512'(32'h6162_6380));
        chk("abc_w15", 512'(last_blk[31:0]), 512'(32'h0000_0018));
        chk("abc_mid", 512'(last_blk[479:32]), 512'(0));
        run_msg(32'h0100, 55, 1);
        chk("s55_w15", 512'(last_blk[31:0]), 512'(32'h0000_01B8));
        chk("s55_w14", 512'(last_blk[63:32]), 512'(0));
        run_msg(32'h0200, 56, 0);
        chk("s56_w15", 512'(last_blk[31:0]), 512'(32'h0000_01C0));
        run_msg(32'h0300, 64, 2);
        chk("s64_w0", 512'(last_blk[511:480]), 512'(32'h8000_0000));
        chk("s64_w15", 512'(last_blk[31:0]), 512'(32'h0000_0200));
        run_msg(32'h0400, 0, 0);
        chk("s0_blk", last_blk, {32'h8000_0000, 480'd0});
        run_msg(32'h0500, 20, 10);
        run_msg(32'hFFF8, 130, 1);

        for (int t = 0; t < 10; t++)
            run_msg(($urandom_range(0, 3) == 0) ? 32'h0000_FFFA : $urandom,
                    int'($urandom_range(0, 300)), int'($urandom_range(0, 3)));

        run_msg(32'h0600, 100, 0, 5);
        reset = 1'b1;
        #1;
        chk_reset_state("arst");
        @(posedge clk); #1;
        chk_reset_state("arst2");
        reset = 1'b0;
        last_addr = '0;
        @(posedge clk); #1;
        run_msg(32'h0040, 3, 0);
        chk("post_rst_w0", 512'(last_blk[511:480]), 512'(32'h6162_6380));
        chk("post_rst_w15", 512'(last_blk[31:0]), 512'(32'h0000_0018));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
